// File: rtl/alu_pkg.sv
// Opcodes, FSM encoding and small helpers shared
// by the alu_mdu execute unit.
package alu_pkg;

   localparam logic [3:0] OP_ADDU  = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_SUBU  = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_NAND  = 4'b0101;
   localparam logic [3:0] OP_MULTU = 4'b0110;
   localparam logic [3:0] OP_SLL   = 4'b0111;
   localparam logic [3:0] OP_SRL   = 4'b1000;
   localparam logic [3:0] OP_SLA   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_SLT   = 4'b1011;
   localparam logic [3:0] OP_SEQ   = 4'b1100;
   localparam logic [3:0] OP_SNE   = 4'b1101;
   localparam logic [3:0] OP_SLTU  = 4'b1110;
   localparam logic [3:0] OP_DIVU  = 4'b1111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic logic is_multi(input logic [3:0] op);
      return (op == OP_MULTU) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response handshake bundle between the
// issue logic and the alu_mdu execute unit.
interface alu_mdu_if #(
   parameter int WIDTH = 32
) ();

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             kill;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cond;
   logic             overflow;
   logic             dbz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output in_valid, op, a, b, kill, out_ready,
      input  in_ready, out_valid, result, cond,
      input  overflow, dbz, hi, lo
   );

   modport slave (
      input  in_valid, op, a, b, kill, out_ready,
      output in_ready, out_valid, result, cond,
      output overflow, dbz, hi, lo
   );

endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider
// sharing one 2*WIDTH working register.
module muldiv_seq #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int PW = WIDTH + MUL_STEP;

   logic [2*WIDTH-1:0] p;
   logic [2*WIDTH-1:0] p_mul;
   logic [2*WIDTH-1:0] p_div;
   logic [WIDTH-1:0]   dvs;
   logic [CW-1:0]      cnt;
   logic               busy_q;
   logic               div_q;
   logic               fast;
   logic [PW-1:0]      pp;
   logic [PW-1:0]      acc;
   logic [WIDTH:0]     shl;
   logic [WIDTH:0]     trial;

   // Divide by zero completes combinationally in the accept cycle
   assign fast = start && is_div && (b == '0);

   always_comb begin
      pp = '0;
      for (int k = 0; k < MUL_STEP; k++) begin
         if (p[k]) pp = pp + ({{MUL_STEP{1'b0}}, dvs} << k);
      end
   end

   assign acc = {{MUL_STEP{1'b0}}, p[2*WIDTH-1:WIDTH]} + pp;
   assign p_mul = {acc, p[WIDTH-1:MUL_STEP]};

   // Upper half is the partial remainder, lower half the quotient
   assign shl = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
   assign trial = shl - {1'b0, dvs};
   assign p_div = trial[WIDTH]
      ? {shl[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
      : {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p      <= '0;
         dvs    <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         div_q  <= 1'b0;
      end else if (abort) begin
         busy_q <= 1'b0;
         cnt    <= '0;
      end else if (start && !fast) begin
         busy_q <= 1'b1;
         div_q  <= is_div;
         dvs    <= b;
         p      <= {{WIDTH{1'b0}}, a};
         cnt    <= is_div ? CW'(WIDTH)
                          : CW'(WIDTH / MUL_STEP);
      end else if (busy_q) begin
         if (cnt != '0) begin
            p   <= div_q ? p_div : p_mul;
            cnt <= cnt - CW'(1);
         end else begin
            busy_q <= 1'b0;
         end
      end
   end

   assign busy = busy_q;
   assign done = fast || (busy_q && (cnt == '0));
   assign hi   = fast ? a : p[2*WIDTH-1:WIDTH];
   assign lo   = fast ? {WIDTH{1'b1}} : p[WIDTH-1:0];
   assign dbz  = fast;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with single-cycle ops and an iterative
// multiply/divide unit behind one registered output.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input logic       clk,
   input logic       rst_n,
   alu_mdu_if.slave  bus
);

   localparam int SW = $clog2(WIDTH);

   logic [1:0]       state;
   logic             vld;
   logic [WIDTH-1:0] res_q;
   logic             cnd_q;
   logic             ovf_q;
   logic             dbz_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic             fire;
   logic             multi;
   logic             seq_busy;
   logic             seq_done;
   logic             seq_dbz;
   logic [WIDTH-1:0] seq_hi;
   logic [WIDTH-1:0] seq_lo;

   logic [SW-1:0]    sh;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] dif;
   logic [WIDTH-1:0] nb;
   logic             lt_s;
   logic             lt_u;
   logic             eq;
   logic [WIDTH-1:0] alu_r;
   logic             alu_c;
   logic             alu_o;

   assign bus.in_ready = rst_n && (state == ST_IDLE)
                      && (!vld || bus.out_ready)
                      && !bus.kill;
   assign fire  = bus.in_valid && bus.in_ready;
   assign multi = is_multi(bus.op);

   muldiv_seq #(
      .WIDTH    (WIDTH),
      .MUL_STEP (MUL_STEP)
   ) u_seq (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (fire && multi),
      .abort  (bus.kill),
      .is_div (bus.op == OP_DIVU),
      .a      (bus.a),
      .b      (bus.b),
      .busy   (seq_busy),
      .done   (seq_done),
      .hi     (seq_hi),
      .lo     (seq_lo),
      .dbz    (seq_dbz)
   );

   assign sh   = bus.b[SW-1:0];
   assign sum  = bus.a + bus.b;
   assign dif  = bus.a - bus.b;
   assign nb   = ~bus.b + WIDTH'(1);
   assign lt_s = $signed(bus.a) < $signed(bus.b);
   assign lt_u = bus.a < bus.b;
   assign eq   = bus.a == bus.b;

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_o = 1'b0;
      unique case (bus.op)
         OP_ADDU: alu_r = sum;
         OP_ADD: begin
            alu_r = sum;
            alu_o = (bus.a[WIDTH-1] == bus.b[WIDTH-1])
                 && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r = dif;
            alu_o = (bus.a[WIDTH-1] == nb[WIDTH-1])
                 && (dif[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUBU: alu_r = dif;
         OP_NOR:  alu_r = ~(bus.a | bus.b);
         OP_NAND: alu_r = ~(bus.a & bus.b);
         OP_SLL,
         OP_SLA:  alu_r = bus.a << sh;
         OP_SRL:  alu_r = bus.a >> sh;
         OP_SRA:  alu_r = $signed(bus.a) >>> sh;
         OP_SLT: begin
            alu_r = {{(WIDTH-1){1'b0}}, lt_s};
            alu_c = lt_s;
         end
         OP_SLTU: begin
            alu_r = {{(WIDTH-1){1'b0}}, lt_u};
            alu_c = lt_u;
         end
         OP_SEQ: begin
            alu_r = {{(WIDTH-1){1'b0}}, eq};
            alu_c = eq;
         end
         OP_SNE:  alu_c = !eq;
         OP_MULTU,
         OP_DIVU: alu_r = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         vld   <= 1'b0;
         res_q <= '0;
         cnd_q <= 1'b0;
         ovf_q <= 1'b0;
         dbz_q <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else if (bus.kill) begin
         // Squash beats completion; HI/LO keep pre-op values
         state <= ST_IDLE;
         vld   <= 1'b0;
      end else begin
         if (vld && bus.out_ready) vld <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (fire && multi) begin
                  res_q <= '0;
                  cnd_q <= 1'b0;
                  ovf_q <= 1'b0;
                  dbz_q <= 1'b0;
                  if (seq_done) begin
                     hi_q  <= seq_hi;
                     lo_q  <= seq_lo;
                     dbz_q <= seq_dbz;
                     vld   <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     state <= (bus.op == OP_DIVU)
                            ? ST_DIV : ST_MUL;
                  end
               end else if (fire) begin
                  res_q <= alu_r;
                  cnd_q <= alu_c;
                  ovf_q <= alu_o;
                  dbz_q <= 1'b0;
                  vld   <= 1'b1;
               end
            end
            ST_MUL,
            ST_DIV: begin
               if (seq_done) begin
                  hi_q  <= seq_hi;
                  lo_q  <= seq_lo;
                  dbz_q <= seq_dbz;
                  vld   <= 1'b1;
                  state <= ST_DONE;
               end else if (!seq_busy) begin
                  state <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.out_valid = vld;
   assign bus.result    = res_q;
   assign bus.cond      = cnd_q;
   assign bus.overflow  = ovf_q;
   assign bus.dbz       = dbz_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu, with a
// second instance at MUL_STEP=4 for the latency case.
module tb_alu_mdu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_mdu_if #(.WIDTH(32)) bus ();
   alu_mdu_if #(.WIDTH(32)) bus4 ();

   alu_mdu #(.WIDTH(32), .MUL_STEP(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   alu_mdu #(.WIDTH(32), .MUL_STEP(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic [3:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
      bus.in_valid = 1'b1;
      bus.op = o;
      bus.a = x;
      bus.b = y;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0;
      bus.kill = 0; bus.out_ready = 1;
      bus4.in_valid = 0; bus4.op = 0; bus4.a = 0; bus4.b = 0;
      bus4.kill = 0; bus4.out_ready = 1;
      rst_n = 0;
      tick();
      tick();
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
      end
      checks++;
      if ({bus.out_valid, bus.cond, bus.overflow, bus.dbz} !== 4'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000",
                  {bus.out_valid, bus.cond, bus.overflow, bus.dbz});
      end
      checks++;
      if ({bus.result, bus.hi, bus.lo} !== 96'h0) begin
         failures++;
         $display("FAIL reset_regs got=%h %h %h exp=0", bus.result, bus.hi, bus.lo);
      end
      rst_n = 1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready);
      end
      tick();
   endtask

   task automatic test_arith();
      logic [3:0]  ops [4] = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU};
      logic [31:0] av  [4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bv  [4] = '{32'h1, 32'h1, 32'h1, 32'h1};
      logic [31:0] rv  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
      logic        ov  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], av[i], bv[i]);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.result !== rv[i] || bus.overflow !== ov[i]) begin
            failures++;
            $display("FAIL arith_%0d got v=%b r=%h ov=%b exp v=1 r=%h ov=%b",
                     i, bus.out_valid, bus.result, bus.overflow, rv[i], ov[i]);
         end
      end
   endtask

   task automatic test_compare();
      logic [3:0]  ops [4] = '{OP_SLT, OP_SLTU, OP_SEQ, OP_SNE};
      logic [31:0] av  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5};
      logic [31:0] bv  [4] = '{32'd1, 32'd1, 32'd5, 32'd6};
      logic        cv  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] rv  [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], av[i], bv[i]);
         checks++;
         if (bus.cond !== cv[i] || bus.result !== rv[i]) begin
            failures++;
            $display("FAIL compare_%0d got c=%b r=%h exp c=%b r=%h",
                     i, bus.cond, bus.result, cv[i], rv[i]);
         end
      end
   endtask

   task automatic test_logic_shift();
      logic [3:0]  ops [6] = '{OP_NOR, OP_NAND, OP_SRA, OP_SLL, OP_SRL, OP_SLA};
      logic [31:0] av  [6] = '{32'h0F0F_0000, 32'hFFFF_0000, 32'h8000_0000,
                               32'h1, 32'hF000_0000, 32'h3};
      logic [31:0] bv  [6] = '{32'h00F0_0000, 32'h0F0F_0F0F, 32'h21,
                               32'h24, 32'h4, 32'h41};
      logic [31:0] rv  [6] = '{32'hF000_FFFF, 32'hF0F0_FFFF, 32'hC000_0000,
                               32'h10, 32'h0F00_0000, 32'h6};
      for (int i = 0; i < 6; i++) begin
         issue(ops[i], av[i], bv[i]);
         checks++;
         if (bus.result !== rv[i] || bus.cond !== 1'b0) begin
            failures++;
            $display("FAIL logic_%0d got r=%h c=%b exp r=%h c=0",
                     i, bus.result, bus.cond, rv[i]);
         end
      end
   endtask

   task automatic test_multu();
      int n;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 33) begin
         failures++;
         $display("FAIL multu_latency got=%0d exp=33", n);
      end
      checks++;
      if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE || bus.result !== 32'd0) begin
         failures++;
         $display("FAIL multu_value got hi=%h lo=%h r=%h exp hi=1 lo=fffffffe r=0",
                  bus.hi, bus.lo, bus.result);
      end
      tick();
   endtask

   task automatic test_divu();
      int n;
      issue(OP_DIVU, 32'd100, 32'd7);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 33) begin
         failures++;
         $display("FAIL divu_latency got=%0d exp=33", n);
      end
      checks++;
      if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || bus.dbz !== 1'b0) begin
         failures++;
         $display("FAIL divu_value got lo=%0d hi=%0d dbz=%b exp lo=14 hi=2 dbz=0",
                  bus.lo, bus.hi, bus.dbz);
      end
      tick();
      issue(OP_DIVU, 32'd9, 32'd0);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL dbz_latency got out_valid=%b exp=1", bus.out_valid);
      end
      checks++;
      if (bus.dbz !== 1'b1 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd9) begin
         failures++;
         $display("FAIL dbz_value got dbz=%b lo=%h hi=%h exp dbz=1 lo=ffffffff hi=9",
                  bus.dbz, bus.lo, bus.hi);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 0;
      issue(OP_SUB, 32'd3, 32'd5);
      bus.in_valid = 1;
      bus.op = OP_ADDU;
      bus.a = 32'd0;
      bus.b = 32'd10;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFF_FFFE || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_%0d got v=%b r=%h rdy=%b exp v=1 r=fffffffe rdy=0",
                     i, bus.out_valid, bus.result, bus.in_ready);
         end
         tick();
      end
      bus.out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         bus.a = i;
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.result !== 32'(i + 10)) begin
            failures++;
            $display("FAIL stream_%0d got v=%b r=%0d exp v=1 r=%0d",
                     i, bus.out_valid, bus.result, i + 10);
         end
      end
      bus.in_valid = 0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_drain got out_valid=%b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_kill();
      bit seen;
      int n;
      issue(OP_MULTU, 32'd3, 32'd4);
      repeat (8) tick();
      bus.kill = 1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL kill_in_ready got=%b exp=0", bus.in_ready);
      end
      tick();
      bus.kill = 0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL kill_state got v=%b rdy=%b exp v=0 rdy=1",
                  bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.hi !== 32'd9 || bus.lo !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL kill_hilo got hi=%h lo=%h exp hi=9 lo=ffffffff", bus.hi, bus.lo);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.out_valid) seen = 1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL kill_no_result got out_valid=1 exp=0");
      end
      issue(OP_MULTU, 32'd3, 32'd4);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 33 || bus.lo !== 32'd12 || bus.hi !== 32'd0) begin
         failures++;
         $display("FAIL post_kill_multu got n=%0d lo=%0d hi=%0d exp n=33 lo=12 hi=0",
                  n, bus.lo, bus.hi);
      end
      tick();
   endtask

   task automatic test_step4();
      int n;
      bus4.in_valid = 1;
      bus4.op = OP_MULTU;
      bus4.a = 32'hFFFF_FFFF;
      bus4.b = 32'd2;
      tick();
      bus4.in_valid = 0;
      n = 0;
      while (!bus4.out_valid && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 9) begin
         failures++;
         $display("FAIL step4_latency got=%0d exp=9", n);
      end
      checks++;
      if (bus4.hi !== 32'd1 || bus4.lo !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL step4_value got hi=%h lo=%h exp hi=1 lo=fffffffe",
                  bus4.hi, bus4.lo);
      end
      tick();
   endtask

   task automatic test_reset_mid_divu();
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (5) tick();
      rst_n = 0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.dbz !== 1'b0 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL midrst_flags got v=%b dbz=%b rdy=%b exp 0 0 0",
                  bus.out_valid, bus.dbz, bus.in_ready);
      end
      checks++;
      if ({bus.result, bus.hi, bus.lo} !== 96'h0) begin
         failures++;
         $display("FAIL midrst_regs got r=%h hi=%h lo=%h exp 0",
                  bus.result, bus.hi, bus.lo);
      end
      rst_n = 1;
      tick();
   endtask

   initial begin
      test_reset();
      test_arith();
      test_compare();
      test_logic_shift();
      test_multu();
      test_divu();
      test_back_to_back();
      test_kill();
      test_step4();
      test_reset_mid_divu();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
